riscv_pipe_ctrl: RTL

RISCV_PIPE_CTRL -- requirements
Module: riscv_pipe_ctrl

---
 rtl/riscv_pipe_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with a saturating stall counter.
// Defining STALL_WDT_EN adds a sticky watchdog on long stall runs.
module riscv_pipe_ctrl #(
  parameter int WDT_LIMIT = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             stallreq_wb_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [4:0]       stall_o,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             wdt_err_o
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state;
  logic [31:0] pend_pc;
  logic        take;

  // The oldest stalling stage freezes itself and everything younger.
  always_comb begin
    if (stallreq_wb_i)       stall_o = 5'b11111;
    else if (stallreq_mem_i) stall_o = 5'b01111;
    else if (stallreq_ex_i)  stall_o = 5'b00111;
    else if (stallreq_id_i)  stall_o = 5'b00011;
    else if (stallreq_if_i)  stall_o = 5'b00001;
    else                     stall_o = 5'b00000;
  end

  // A branch seen while EX is held is ignored; EX presents it again later.
  assign take = branch_taken_i & ~stall_o[2];

  always_comb begin
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    if (!rst) begin
      if (state == PEND) begin
        flush_o = 1'b1;
        if (!stallreq_if_i) begin
          redirect_o    = 1'b1;
          redirect_pc_o = take ? branch_target_i : pend_pc;
        end
      end else if (take) begin
        flush_o = 1'b1;
        if (!stallreq_if_i) begin
          redirect_o    = 1'b1;
          redirect_pc_o = branch_target_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pend_pc <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (take && stallreq_if_i) begin
            state   <= PEND;
            pend_pc <= branch_target_i;
          end
        end
        PEND: begin
          if (take) pend_pc <= branch_target_i;
          if (!stallreq_if_i) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if ((stall_o != 5'b00000) && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef STALL_WDT_EN
  localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);

  logic [15:0] wdt_cnt;
  logic        wdt_err;

  // Counts back-to-back stalled cycles; the error latches until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt <= 16'h0;
      wdt_err <= 1'b0;
    end else if (stall_o == 5'b00000) begin
      wdt_cnt <= 16'h0;
    end else begin
      if (wdt_cnt != 16'hFFFF) wdt_cnt <= wdt_cnt + 16'd1;
      if ((wdt_cnt + 16'd1) == WDT_MAX) wdt_err <= 1'b1;
    end
  end

  assign wdt_err_o = wdt_err;
`else
  assign wdt_err_o = 1'b0;
`endif

endmodule
